accum_key_arbiter: RTL and testbench

- Owns the 8-bit accumulator that drives the board LEDs.
- Shares it between two requesters: the push-key path (accumulate / clear keys plus switches) and the NIOS II CPU over an Avalon-MM slave port.
- Sits inside the SoC between the key/switch PIO inputs and the LED output.
- Debounces the keys, arbitrates update requests, and keeps sticky overflow/drop status.

---
 rtl/accum_pkg.sv | 26 ++
 rtl/key_debounce.sv | 64 ++++++
 rtl/accum_key_arbiter.sv | 171 +++++++++++++++++
 tb/tb_accum_key_arbiter.sv | 315 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/accum_pkg.sv
// Shared definitions for the LED accumulator: register map, STATUS bit positions, grant codes.
// No logic; constants and types only.
// No flow control of its own.
package accum_pkg;

  // Avalon word addresses
  localparam logic [1:0] ADDR_ACC    = 2'd0;
  localparam logic [1:0] ADDR_ADD    = 2'd1;
  localparam logic [1:0] ADDR_STATUS = 2'd2;
  localparam logic [1:0] ADDR_EVCNT  = 2'd3;

  // STATUS register bit positions
  localparam int STAT_OVF  = 0;
  localparam int STAT_DROP = 1;
  localparam int STAT_PEND = 2;
  localparam int STAT_IE   = 3;

  // Winner of the per-cycle accumulator update arbitration
  typedef enum logic [1:0] {
    GNT_NONE,
    GNT_CLR,
    GNT_CPU,
    GNT_KEY
  } gnt_e;

endpackage

// File: rtl/key_debounce.sv
// Key debouncer: 2-FF synchronizer, stable-sample counter, accepted level; one-cycle press pulse on 1->0.
// Latency: 2 sync cycles + DEBOUNCE_CYCLES stable samples + 1 registered pulse cycle.
// No backpressure: the press pulse is emitted once and never held.
module key_debounce #(
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic key_n,
  output logic press
);

  localparam int               CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync1_q, sync2_q;
  logic             level_q, level_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             press_q, press_d;

  // Bring the asynchronous key pin into the clock domain; idles at "released".
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
    end else begin
      sync1_q <= key_n;
      sync2_q <= sync1_q;
    end
  end

  // Count consecutive samples disagreeing with the accepted level; the last one flips it.
  // The count never passes CNT_LAST, since reaching it either flips or restarts.
  always_comb begin
    level_d = level_q;
    cnt_d   = cnt_q;
    press_d = 1'b0;
    if (sync2_q == level_q) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_LAST) begin
      level_d = sync2_q;
      cnt_d   = '0;
      press_d = level_q;  // old level high means the key just went down
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // Debounce state; reset lands in "released" with no pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      level_q <= 1'b1;
      cnt_q   <= '0;
      press_q <= 1'b0;
    end else begin
      level_q <= level_d;
      cnt_q   <= cnt_d;
      press_q <= press_d;
    end
  end

  assign press = press_q;

endmodule

// File: rtl/accum_key_arbiter.sv
// LED accumulator shared by the debounced keys and an Avalon-MM CPU port (ACCUM_IRQ_EN enables irq/IE).
// Latency: updates land one cycle after grant; reads return one cycle after avs_read.
// Backpressure: avs_waitrequest only when a CPU ACC/ADD write meets a clear event; key adds hold 1 deep.
module accum_key_arbiter
  import accum_pkg::*;
#(
  parameter int DATA_W          = 8,
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int EVCNT_W         = 16
) (
  input  logic              clk_clk,
  input  logic              reset_reset_n,
  input  logic              accumulate_export,
  input  logic              reset_accumulate_export,
  input  logic [DATA_W-1:0] sw_export,
  input  logic [1:0]        avs_address,
  input  logic              avs_read,
  input  logic              avs_write,
  input  logic [31:0]       avs_writedata,
  output logic [31:0]       avs_readdata,
  output logic              avs_waitrequest,
  output logic [DATA_W-1:0] led_export,
  output logic              irq
);

  logic               acc_press, clr_press;
  logic [DATA_W-1:0]  acc_q, acc_d;
  logic               ovf_q, ovf_d, drop_q, drop_d, pend_q, pend_d;
  logic               ie_q, ie_d, irq_q, irq_d;
  logic [EVCNT_W-1:0] evcnt_q, evcnt_d;
  logic [31:0]        rdata_q, rdata_d;
  logic [31:0]        status_word;
  logic [DATA_W-1:0]  addend;
  logic [DATA_W:0]    sum;
  logic               cpu_acc_wr, status_wr, set_ovf, set_drop;
  gnt_e               gnt;
  logic               unused_wdata;

  assign unused_wdata = ^avs_writedata[31:DATA_W];

  key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_acc_key (
    .clk   (clk_clk),
    .rst_n (reset_reset_n),
    .key_n (accumulate_export),
    .press (acc_press)
  );

  key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_clr_key (
    .clk   (clk_clk),
    .rst_n (reset_reset_n),
    .key_n (reset_accumulate_export),
    .press (clr_press)
  );

  // Pick the single accumulator writer for this cycle: clear, then CPU, then key.
  always_comb begin
    cpu_acc_wr = avs_write && ((avs_address == ADDR_ACC) || (avs_address == ADDR_ADD));
    status_wr  = avs_write && (avs_address == ADDR_STATUS);
    if (clr_press)                gnt = GNT_CLR;
    else if (cpu_acc_wr)          gnt = GNT_CPU;
    else if (pend_q || acc_press) gnt = GNT_KEY;
    else                          gnt = GNT_NONE;
  end

  // A CPU accumulator write that loses to a clear is stalled; the master retries it next cycle.
  assign avs_waitrequest = clr_press & cpu_acc_wr;

  // Apply the granted update and maintain pending/drop/overflow/event bookkeeping.
  always_comb begin
    acc_d    = acc_q;
    pend_d   = pend_q;
    evcnt_d  = evcnt_q;
    ovf_d    = ovf_q;
    drop_d   = drop_q;
    set_ovf  = 1'b0;
    set_drop = 1'b0;
    addend   = (gnt == GNT_KEY) ? sw_export : avs_writedata[DATA_W-1:0];
    sum      = {1'b0, acc_q} + {1'b0, addend};
`ifdef ACCUM_IRQ_EN
    ie_d     = ie_q;
    irq_d    = ovf_q & ie_q;
`else
    ie_d     = 1'b0;
    irq_d    = 1'b0;
`endif
    case (gnt)
      // A clear also throws away a held key add and any key press landing with it.
      GNT_CLR: begin
        acc_d  = '0;
        pend_d = 1'b0;
      end
      GNT_CPU: begin
        if (avs_address == ADDR_ACC) begin
          acc_d = avs_writedata[DATA_W-1:0];
        end else begin
          acc_d   = sum[DATA_W-1:0];
          set_ovf = sum[DATA_W];
        end
        if (acc_press) begin
          set_drop = pend_q;
          pend_d   = 1'b1;
        end
      end
      // The held press is served first; a new press arriving alongside it is lost.
      GNT_KEY: begin
        acc_d    = sum[DATA_W-1:0];
        set_ovf  = sum[DATA_W];
        set_drop = pend_q & acc_press;
        pend_d   = 1'b0;
        evcnt_d  = evcnt_q + 1'b1;
      end
      default: ;
    endcase
    if (status_wr) begin
      if (avs_writedata[STAT_OVF])  ovf_d  = 1'b0;
      if (avs_writedata[STAT_DROP]) drop_d = 1'b0;
`ifdef ACCUM_IRQ_EN
      ie_d = avs_writedata[STAT_IE];
`endif
    end
    // New events beat a same-cycle write-1-clear.
    if (set_ovf)  ovf_d  = 1'b1;
    if (set_drop) drop_d = 1'b1;
  end

  // Read mux sees pre-update state; readdata holds between reads.
  always_comb begin
    status_word            = '0;
    status_word[STAT_OVF]  = ovf_q;
    status_word[STAT_DROP] = drop_q;
    status_word[STAT_PEND] = pend_q;
    status_word[STAT_IE]   = ie_q;
    rdata_d                = rdata_q;
    if (avs_read) begin
      case (avs_address)
        ADDR_ACC:    rdata_d = 32'(acc_q);
        ADDR_STATUS: rdata_d = status_word;
        ADDR_EVCNT:  rdata_d = 32'(evcnt_q);
        default:     rdata_d = '0;
      endcase
    end
  end

  // Register file and accumulator state.
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      acc_q   <= '0;
      pend_q  <= 1'b0;
      evcnt_q <= '0;
      ovf_q   <= 1'b0;
      drop_q  <= 1'b0;
      ie_q    <= 1'b0;
      irq_q   <= 1'b0;
      rdata_q <= '0;
    end else begin
      acc_q   <= acc_d;
      pend_q  <= pend_d;
      evcnt_q <= evcnt_d;
      ovf_q   <= ovf_d;
      drop_q  <= drop_d;
      ie_q    <= ie_d;
      irq_q   <= irq_d;
      rdata_q <= rdata_d;
    end
  end

  assign led_export   = acc_q;
  assign avs_readdata = rdata_q;
  assign irq          = irq_q;

endmodule

// File: tb/tb_accum_key_arbiter.sv
// Self-checking bench for accum_key_arbiter against a cycle-level reference model.
// Directed scenarios first, then randomized keys, switches and Avalon traffic.
// Avalon writes are held while a stall is expected.
module tb_accum_key_arbiter;

  localparam int D = 4;
`ifdef ACCUM_IRQ_EN
  localparam logic [31:0] IEV = 32'h8;
`else
  localparam logic [31:0] IEV = 32'h0;
`endif

  logic        clk_clk = 1'b0;
  logic        reset_reset_n;
  logic        accumulate_export, reset_accumulate_export;
  logic [7:0]  sw_export;
  logic [1:0]  avs_address;
  logic        avs_read, avs_write;
  logic [31:0] avs_writedata, avs_readdata;
  logic        avs_waitrequest, irq;
  logic [7:0]  led_export;

  accum_key_arbiter #(.DATA_W(8), .DEBOUNCE_CYCLES(D), .EVCNT_W(16)) dut (
    .clk_clk                 (clk_clk),
    .reset_reset_n           (reset_reset_n),
    .accumulate_export       (accumulate_export),
    .reset_accumulate_export (reset_accumulate_export),
    .sw_export               (sw_export),
    .avs_address             (avs_address),
    .avs_read                (avs_read),
    .avs_write               (avs_write),
    .avs_writedata           (avs_writedata),
    .avs_readdata            (avs_readdata),
    .avs_waitrequest         (avs_waitrequest),
    .led_export              (led_export),
    .irq                     (irq)
  );

  always #5 clk_clk = ~clk_clk;

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  logic [7:0]   m_acc;
  logic [15:0]  m_evcnt;
  bit           m_ovf, m_drop, m_pend, m_ie, m_irq;
  logic [31:0]  m_rd;
  bit           m_press[2];     // debounced press that the next clock edge acts on
  bit           m_lvl[2];       // accepted key level
  logic [D+1:0] hist[2];        // raw key samples, newest in bit 0

  task automatic model_reset();
    m_acc = 0; m_evcnt = 0; m_ovf = 0; m_drop = 0; m_pend = 0; m_ie = 0; m_irq = 0; m_rd = 0;
    for (int k = 0; k < 2; k++) begin
      m_press[k] = 0; m_lvl[k] = 1; hist[k] = '1;
    end
  endtask

  function automatic logic [31:0] m_reg(input logic [1:0] a);
    case (a)
      2'd0:    return {24'b0, m_acc};
      2'd2:    return {28'b0, m_ie, m_pend, m_drop, m_ovf};
      2'd3:    return {16'b0, m_evcnt};
      default: return 32'b0;
    endcase
  endfunction

  function automatic bit exp_wait();
    return m_press[1] && avs_write && (avs_address < 2'd2);
  endfunction

  task automatic model_edge();
    bit ev_acc, ev_clr, set_ovf, set_drop, new_irq;
    int s;
    logic key_now[2];
    ev_acc = m_press[0]; ev_clr = m_press[1]; set_ovf = 0; set_drop = 0;
    if (avs_read) m_rd = m_reg(avs_address);
`ifdef ACCUM_IRQ_EN
    new_irq = m_ovf && m_ie;
`else
    new_irq = 0;
`endif
    if (ev_clr) begin
      m_acc = 0; m_pend = 0;
    end else if (avs_write && avs_address < 2'd2) begin
      if (avs_address == 2'd0) m_acc = avs_writedata[7:0];
      else begin
        s = int'(m_acc) + int'(avs_writedata[7:0]);
        if (s > 255) set_ovf = 1;
        m_acc = 8'(s);
      end
      if (ev_acc) begin
        if (m_pend) set_drop = 1;
        m_pend = 1;
      end
    end else if (m_pend || ev_acc) begin
      s = int'(m_acc) + int'(sw_export);
      if (s > 255) set_ovf = 1;
      m_acc = 8'(s);
      if (m_pend && ev_acc) set_drop = 1;
      m_pend = 0;
      m_evcnt = m_evcnt + 16'd1;
    end
    if (avs_write && avs_address == 2'd2) begin
      if (avs_writedata[0]) m_ovf = 0;
      if (avs_writedata[1]) m_drop = 0;
`ifdef ACCUM_IRQ_EN
      m_ie = avs_writedata[3];
`endif
    end
    if (set_ovf) m_ovf = 1;
    if (set_drop) m_drop = 1;
    m_irq = new_irq;
    // a level is accepted after D consecutive equal samples seen through the 2-FF synchronizer
    key_now[0] = accumulate_export;
    key_now[1] = reset_accumulate_export;
    for (int k = 0; k < 2; k++) begin
      hist[k] = {hist[k][D:0], key_now[k]};
      m_press[k] = 0;
      if (hist[k][D+1:2] == {D{~m_lvl[k]}}) begin
        m_press[k] = m_lvl[k];
        m_lvl[k] = ~m_lvl[k];
      end
    end
  endtask

  // ---------------- stimulus helpers ----------------
  task automatic cyc();
    bit ew;
    ew = exp_wait();
    #1 chk("waitreq", 32'(avs_waitrequest), 32'(ew));
    @(posedge clk_clk);
    model_edge();
    @(negedge clk_clk);
    chk("led", 32'(led_export), 32'(m_acc));
    chk("irq", 32'(irq), 32'(m_irq));
    chk("readdata", avs_readdata, m_rd);
  endtask

  task automatic rd(input logic [1:0] a);
    avs_read = 1; avs_address = a;
    cyc();
    avs_read = 0;
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    bit st;
    avs_write = 1; avs_address = a; avs_writedata = d;
    for (int i = 0; i < 4; i++) begin
      st = exp_wait();
      cyc();
      if (!st) break;
    end
    avs_write = 0;
  endtask

  task automatic wait_press(input int k, input int maxc);
    for (int i = 0; i < maxc; i++) begin
      if (m_press[k]) break;
      cyc();
    end
    chk("press_seen", 32'(m_press[k]), 32'd1);
  endtask

  int bounce_len[5] = '{2, 1, 3, 2, 8};
  int klen[2];
  bit hold;
  logic [15:0] ev0;

  initial begin
    accumulate_export = 1; reset_accumulate_export = 1; sw_export = 0;
    avs_address = 0; avs_read = 0; avs_write = 0; avs_writedata = 0;
    reset_reset_n = 0;
    model_reset();
    repeat (3) @(negedge clk_clk);
    #1;
    chk("rst_led", 32'(led_export), 32'd0);
    chk("rst_irq", 32'(irq), 32'd0);
    chk("rst_wait", 32'(avs_waitrequest), 32'd0);
    chk("rst_rdata", avs_readdata, 32'd0);
    @(negedge clk_clk);
    reset_reset_n = 1;
    rd(2'd2); chk("rst_status", avs_readdata, 32'd0);
    rd(2'd3); chk("rst_evcnt", avs_readdata, 32'd0);

    // three clean presses, sw = 5
    sw_export = 8'h05;
    repeat (3) begin
      accumulate_export = 0; repeat (D + 4) cyc();
      accumulate_export = 1; repeat (D + 4) cyc();
    end
    chk("three_press_led", 32'(led_export), 32'h0F);
    rd(2'd3); chk("three_press_evcnt", avs_readdata, 32'd3);

    // bouncing press: short runs, then stable low -> one add
    for (int i = 0; i < 5; i++) begin
      accumulate_export = (i % 2 == 1);
      repeat (bounce_len[i]) cyc();
    end
    accumulate_export = 1; repeat (D + 4) cyc();
    chk("bounce_led", 32'(led_export), 32'h14);
    rd(2'd3); chk("bounce_evcnt", avs_readdata, 32'd4);

    // CPU add overflow, IE and W1C
    wr(2'd0, 32'hFE);
    wr(2'd2, 32'h8);
    wr(2'd1, 32'h03);
    chk("ovf_led", 32'(led_export), 32'h01);
    rd(2'd2); chk("ovf_status", avs_readdata, 32'h1 | IEV);
    chk("ovf_irq", 32'(irq), 32'(IEV != 0));
    wr(2'd2, 32'h1 | IEV);
    cyc();
    chk("w1c_irq", 32'(irq), 32'd0);
    rd(2'd2); chk("w1c_status", avs_readdata, IEV);
    wr(2'd2, 32'h3);

    // CPU write coincident with accumulate event
    sw_export = 8'h01;
    accumulate_export = 0;
    wait_press(0, 20);
    avs_write = 1; avs_address = 2'd0; avs_writedata = 32'h40;
    cyc();
    avs_write = 0;
    chk("coinc_led1", 32'(led_export), 32'h40);
    rd(2'd2); chk("coinc_pend", avs_readdata, 32'h4);
    chk("coinc_led2", 32'(led_export), 32'h41);
    rd(2'd2); chk("coinc_pend_clr", avs_readdata, 32'h0);
    accumulate_export = 1; repeat (D + 4) cyc();

    // clear event coincident with CPU write -> stall one cycle
    reset_accumulate_export = 0;
    wait_press(1, 20);
    avs_write = 1; avs_address = 2'd0; avs_writedata = 32'h77;
    #1 chk("stall", 32'(avs_waitrequest), 32'd1);
    cyc();
    chk("stall_led_clr", 32'(led_export), 32'h00);
    cyc();
    chk("stall_led_wr", 32'(led_export), 32'h77);
    avs_write = 0;
    reset_accumulate_export = 1; repeat (D + 4) cyc();

    // second press while one is pending -> DROP, EVCNT +1
    ev0 = m_evcnt;
    accumulate_export = 0;
    wait_press(0, 20);
    avs_write = 1; avs_address = 2'd1; avs_writedata = 32'h0;
    cyc();
    accumulate_export = 1; repeat (D + 4) cyc();
    accumulate_export = 0;
    wait_press(0, 20);
    cyc();
    avs_write = 0;
    cyc();
    rd(2'd2); chk("drop_status", avs_readdata, 32'h2);
    rd(2'd3); chk("drop_evcnt", avs_readdata, 32'(ev0 + 16'd1));
    accumulate_export = 1; repeat (D + 4) cyc();
    wr(2'd2, 32'h3);

    // reset mid-operation with acc=0x33 and a pending add; key held low through reset
    sw_export = 8'h03;
    accumulate_export = 0;
    wait_press(0, 20);
    avs_write = 1; avs_address = 2'd0; avs_writedata = 32'h33;
    cyc();
    avs_write = 0;
    chk("pre_rst_led", 32'(led_export), 32'h33);
    reset_reset_n = 0;
    model_reset();
    #1 chk("mid_rst_led", 32'(led_export), 32'd0);
    repeat (2) @(negedge clk_clk);
    reset_reset_n = 1;
    rd(2'd0); chk("post_rst_acc", avs_readdata, 32'd0);
    rd(2'd2); chk("post_rst_status", avs_readdata, 32'd0);
    rd(2'd3); chk("post_rst_evcnt", avs_readdata, 32'd0);
    repeat (D + 6) cyc();
    chk("held_key_press", 32'(led_export), 32'h03);
    accumulate_export = 1; repeat (D + 4) cyc();

    // randomized traffic
    klen[0] = 0; klen[1] = 0; hold = 0;
    for (int c = 0; c < 1500; c++) begin
      if (klen[0] == 0) begin
        accumulate_export = ~accumulate_export;
        klen[0] = $urandom_range(1, 10);
      end
      if (klen[1] == 0) begin
        reset_accumulate_export = ~reset_accumulate_export;
        klen[1] = reset_accumulate_export ? $urandom_range(5, 40) : $urandom_range(1, 10);
      end
      klen[0]--; klen[1]--;
      if (!hold) begin
        avs_read      = 1'($urandom_range(0, 1));
        avs_write     = ($urandom_range(0, 3) == 0);
        avs_address   = 2'($urandom_range(0, 3));
        avs_writedata = $urandom;
      end
      sw_export = 8'($urandom);
      hold = exp_wait();
      cyc();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
